// File: rtl/alarme_pkg.sv
// Shared types and helpers for the alarm matcher.
// State encoding, clog2 and derived widths.
package alarme_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int ch_w(input int ch);
        return max2(1, clog2(ch));
    endfunction

endpackage

// File: rtl/comparador_n.sv
// Full-width equality comparator.
// One instance per alarm channel.
module comparador_n #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/comparador_alarme.sv
// Multi-channel alarm matcher.
// Edge-detected match feeding a ring/snooze/timeout FSM.
module comparador_alarme
    import alarme_pkg::*;
#(
    parameter int WIDTH        = 12,
    parameter int CHANNELS     = 2,
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZE   = 3,
    localparam int CH_W        = ch_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [WIDTH-1:0]    current_time,
    input  logic                set_valid,
    input  logic [CH_W-1:0]     set_ch,
    input  logic [WIDTH-1:0]    set_time,
    input  logic [CHANNELS-1:0] enable,
    input  logic                dismiss,
    input  logic                snooze,
    output logic                ringing,
    output logic                snoozing,
    output logic [CH_W-1:0]     ring_ch,
    output logic [CHANNELS-1:0] match
);

    localparam int TW = max2(1, clog2(max2(RING_TICKS, SNOOZE_TICKS)));
    localparam int SW = max2(1, clog2(MAX_SNOOZE + 1));
    localparam logic [TW-1:0] RING_LAST = TW'(RING_TICKS - 1);
    localparam logic [TW-1:0] SNZ_LAST  = TW'(SNOOZE_TICKS - 1);
    localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);

    logic [WIDTH-1:0]    alarm [CHANNELS];
    logic [CHANNELS-1:0] eq;
    logic [CHANNELS-1:0] trig;
    logic [CHANNELS-1:0] en_sh;
    logic                en_cur;
    logic                any_trig;
    logic [CH_W-1:0]     win;

    state_t          state, state_n;
    logic [CH_W-1:0] ch_n;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [SW-1:0]   snz_cnt, snz_n;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        comparador_n #(.WIDTH(WIDTH)) u_cmp (
            .a  (current_time),
            .b  (alarm[g]),
            .eq (eq[g])
        );
    end

    assign trig   = eq & ~match & enable;
    assign en_sh  = enable >> ring_ch;
    assign en_cur = en_sh[0];

    assign ringing  = (state == RING);
    assign snoozing = (state == SNOOZE);

    // Alarm storage; out-of-range channel writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) alarm[i] <= '0;
        end else if (set_valid && (int'(set_ch) < CHANNELS)) begin
            alarm[set_ch] <= set_time;
        end
    end

    // Previous-cycle equality; ones at reset block a trigger at time 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match <= '1;
        else        match <= eq;
    end

    // Lowest-index new match wins
    always_comb begin
        win      = '0;
        any_trig = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (trig[i]) begin
                win      = CH_W'(i);
                any_trig = 1'b1;
            end
        end
    end

    // FSM state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_ch  <= '0;
            tick_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            state    <= state_n;
            ring_ch  <= ch_n;
            tick_cnt <= tick_n;
            snz_cnt  <= snz_n;
        end
    end

    // Next-state: disable > dismiss > snooze > tick
    always_comb begin
        state_n = state;
        ch_n    = ring_ch;
        tick_n  = tick_cnt;
        snz_n   = snz_cnt;
        unique case (state)
            IDLE: begin
                if (any_trig) begin
                    state_n = RING;
                    ch_n    = win;
                    tick_n  = '0;
                    snz_n   = '0;
                end
            end
            RING: begin
                if (dismiss || !en_cur) begin
                    state_n = IDLE;
                end else if (snooze) begin
                    if (snz_cnt == SNZ_MAX) begin
                        state_n = IDLE;
                    end else begin
                        state_n = SNOOZE;
                        snz_n   = snz_cnt + 1'b1;
                        tick_n  = '0;
                    end
                end else if (tick) begin
                    if (tick_cnt == RING_LAST) state_n = IDLE;
                    else                       tick_n  = tick_cnt + 1'b1;
                end
            end
            SNOOZE: begin
                if (dismiss || !en_cur) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (tick_cnt == SNZ_LAST) begin
                        state_n = RING;
                        tick_n  = '0;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
